// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension execution unit: funct3 op encoding,
// FSM state encoding and the default datapath width shared with the ALU.
package muldiv_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  // funct3[2] splits the multiply group from the divide/remainder group.
  function automatic logic op_is_div(input muldiv_op_t o);
    return o[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Unsigned radix-2 restoring divider core, one quotient bit per iterate cycle.
// quotient_o/remainder_o show the outcome of the current iteration, so they are final while done_o is high.
module muldiv_unit_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            iterate_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [CW-1:0]   cnt_q;

  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            bit_d;

  // The dividend drains out of the top of quo_q while quotient bits enter at the bottom.
  always_comb begin
    rem_shift   = {rem_q, quo_q[XLEN-1]};
    diff        = rem_shift - {1'b0, dvs_q};
    bit_d       = ~diff[XLEN];
    remainder_o = bit_d ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quotient_o  = {quo_q[XLEN-2:0], bit_d};
  end

  assign done_o = iterate_i && (cnt_q == CW'(XLEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= '0;
    end else if (iterate_i) begin
      quo_q <= quotient_o;
      rem_q <= remainder_o;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV M-extension unit: MUL_STAGES-deep multiplier, XLEN-iteration restoring divider.
// Define MULDIV_DIV_EARLY_OUT_EN to let divide-by-zero and signed overflow skip the divider loop.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enabled,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            completed,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0]      MUL_LAST = 3'(MUL_STAGES - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q;
  muldiv_op_t      op_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [2:0]      cnt_q;
  logic            div_run_q;
  logic            busy_q;
  logic            completed_q;
  logic [XLEN-1:0] result_q;

  // ---------------- multiplier ----------------
  logic                mul_a_sgn;
  logic                mul_b_sgn;
  logic [2*XLEN-1:0]   mul_a;
  logic [2*XLEN-1:0]   mul_b;
  logic [2*XLEN-1:0]   prod_c;
  logic [2*XLEN-1:0]   prod_out;
  logic [XLEN-1:0]     mul_res_d;

  // Sign-extending to 2*XLEN makes the low 2*XLEN bits of an unsigned multiply exact for every signedness mix.
  assign mul_a_sgn = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && rs1_q[XLEN-1];
  assign mul_b_sgn = (op_q == OP_MULH) && rs2_q[XLEN-1];
  assign mul_a     = {{XLEN{mul_a_sgn}}, rs1_q};
  assign mul_b     = {{XLEN{mul_b_sgn}}, rs2_q};
  assign prod_c    = mul_a * mul_b;

  if (MUL_STAGES == 1) begin : g_mul_comb
    assign prod_out = prod_c;
  end else begin : g_mul_pipe
    logic [2*XLEN-1:0] pipe_q [MUL_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < MUL_STAGES - 1; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= prod_c;
        for (int i = 1; i < MUL_STAGES - 1; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign prod_out = pipe_q[MUL_STAGES-2];
  end

  assign mul_res_d = (op_q == OP_MUL) ? prod_out[XLEN-1:0] : prod_out[2*XLEN-1:XLEN];

  // ---------------- divider ----------------
  logic            div_signed;
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] rs1_mag;
  logic [XLEN-1:0] rs2_mag;
  logic            div_by_zero;
  logic            div_ovf;
  logic            div_start;
  logic            div_iterate;
  logic            div_done;
  logic            div_finish;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] div_res_d;

  assign div_signed  = ~op_q[0];
  assign rs1_neg     = div_signed && rs1_q[XLEN-1];
  assign rs2_neg     = div_signed && rs2_q[XLEN-1];
  assign rs1_mag     = rs1_neg ? -rs1_q : rs1_q;
  assign rs2_mag     = rs2_neg ? -rs2_q : rs2_q;
  assign div_by_zero = (rs2_q == '0);
  assign div_ovf     = div_signed && (rs1_q == MOST_NEG) && (rs2_q == '1);

  // First DIV cycle loads magnitudes; the following XLEN cycles each retire one quotient bit.
  assign div_start   = (state_q == ST_DIV) && !div_run_q && !flush;
  assign div_iterate = (state_q == ST_DIV) && div_run_q && !flush;

`ifdef MULDIV_DIV_EARLY_OUT_EN
  assign div_finish = div_done || div_by_zero || div_ovf;
`else
  assign div_finish = div_done;
`endif

  muldiv_unit_div_iter #(
    .XLEN(XLEN)
  ) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .iterate_i  (div_iterate),
    .dividend_i (rs1_mag),
    .divisor_i  (rs2_mag),
    .done_o     (div_done),
    .quotient_o (quo),
    .remainder_o(rem)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  always_comb begin
    q_fix = (rs1_neg ^ rs2_neg) ? -quo : quo;
    r_fix = rs1_neg ? -rem : rem;
    if (div_by_zero) begin
      q_fix = '1;
      r_fix = rs1_q;
    end else if (div_ovf) begin
      q_fix = rs1_q;
      r_fix = '0;
    end
    div_res_d = op_q[1] ? r_fix : q_fix;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      rs1_q       <= '0;
      rs2_q       <= '0;
      cnt_q       <= '0;
      div_run_q   <= 1'b0;
      busy_q      <= 1'b0;
      completed_q <= 1'b0;
      result_q    <= '0;
    end else begin
      completed_q <= 1'b0;
      case (state_q)
        // DONE samples a new request exactly as IDLE does, giving back-to-back issue.
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (enabled && !flush) begin
            op_q      <= op;
            rs1_q     <= rs1;
            rs2_q     <= rs2;
            cnt_q     <= '0;
            div_run_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= op_is_div(op) ? ST_DIV : ST_MUL;
          end
        end
        ST_MUL: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == MUL_LAST) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            completed_q <= 1'b1;
            result_q    <= mul_res_d;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_DIV: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!div_run_q) begin
            div_run_q <= 1'b1;
          end else if (div_finish) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            completed_q <= 1'b1;
            result_q    <= div_res_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign completed = completed_q;
  assign result    = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised, multi-cycle RV M-extension execution unit that replaces single-cycle combinational mul/div in the ALU path.
- Pipelined multiplier with configurable latency; iterative radix-2 restoring divider.
- Start/complete handshake with busy, flush and one-cycle completion pulse.
- Sits beside alu in the execute stage; core steers M-extension ops here and stalls on busy.

Parameters:
XLEN, 32, operand/result width (supported: 32, 64)
MUL_STAGES, 2, multiplier latency in cycles from accept to completed (1..4)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
enabled  in  1  start request; sampled only in IDLE
op  in  3  muldiv_op_t (funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU)
rs1  in  XLEN  operand 1
rs2  in  XLEN  operand 2
flush  in  1  abort in-flight op (trap/branch kill)
busy  out  1  high from accept edge until completion or flush
completed  out  1  one-cycle pulse, result valid
result  out  XLEN  result; held until next completion

Behaviour:
- Reset (async, rst high): state=IDLE, busy=0, completed=0, result=0, all counters 0. Reset mid-operation discards the op with no completed pulse.
- States: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL when enabled && !flush && op<4.
  - IDLE -> DIV when enabled && !flush && op>=4.
  - MUL -> DONE after MUL_STAGES-1 further cycles.
  - DIV -> DONE after XLEN iterations.
  - DONE -> IDLE always. completed=1 only in DONE; busy=0 in DONE.
- Accept at edge E0: op, rs1, rs2 latched; busy=1 from E0.
- Latency, counted as edges after E0 until completed=1:
  - MUL*: L = MUL_STAGES.
  - DIV*/REM*: L = XLEN+1. Setup converts signed operands to magnitude and records signs. XLEN iterations follow; sign fixup occurs on the DONE transition.
- Back-to-back: enabled may be asserted in the DONE cycle. It is accepted, because the FSM returns to IDLE on that edge and the op is sampled as in IDLE. Single-issue only; enabled while busy is ignored with no queuing.
- Flush in any non-IDLE state: IDLE at next edge, no completed, result unchanged.
- Flush and enabled in the same IDLE cycle: flush wins, nothing accepted.
- Arithmetic, 2*XLEN-bit product:
  - MUL = low half.
  - MULH = high half, signed x signed.
  - MULHSU = high half, signed rs1 x unsigned rs2.
  - MULHU = high half, unsigned x unsigned.
- Division by zero: DIV/DIVU quotient = all-ones; REM/REMU = rs1.
- Signed overflow (rs1 = most-negative, rs2 = -1): DIV = rs1, REM = 0.
- Signed remainder takes the sign of the dividend; quotient truncates toward zero.
- No exceptions are raised under any condition.

Optional Feature:
MULDIV_DIV_EARLY_OUT_EN
- Defined: DIV* and REM* with divide-by-zero or signed overflow bypass the iteration loop. They go DIV -> DONE after the setup edge, so L=2.
- Not defined: special cases are resolved at fixup and always take L = XLEN+1. Results are identical in both builds.

Decomposition:
- Shared package (def.sv): muldiv_op_t enum (3-bit, funct3 values above), muldiv_state_t enum, and an XLEN default constant shared with alu.
- Sub-module div_iter: unsigned restoring divider core. It has start/iterate/done ports and quotient/remainder outputs, and handles XLEN-bit magnitudes and one quotient bit per cycle.
- Sign handling, special cases, multiplier pipeline and FSM live in muldiv_unit.

Test Plan:
- XLEN=32, MUL_STAGES=2: MULH rs1=0x80000000, rs2=0x80000000 -> completed 2 edges after accept, result=0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> completed after 33 edges, result=0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU rs2=0, rs1=0x1234 -> 0xFFFFFFFF. REM rs1=0x80000000, rs2=0xFFFFFFFF -> 0. Latency is 33 without the macro and 2 with MULDIV_DIV_EARLY_OUT_EN.
- Start DIV, then assert flush 10 cycles later -> busy drops next edge, no completed pulse, result keeps its prior value. A new MUL 3*5 then returns 15 with normal latency.
- enabled held high through a DIV -> exactly one completion. A second op applied during the DONE cycle is accepted and completes with its own latency.
- Assert rst asynchronously mid-MUL (between edges) -> busy=0, completed=0, result=0 immediately, without waiting for a clock edge.
